alu_ctrl_md: RTL and testbench

- Parametrised successor to the single-cycle ALU controller.
- Keeps the combinational ALUOp/funct decode (ALUCtrl_o, jr_o) and adds an iterative multiply/divide sequencer for mult/multu/div/divu.
- Owns the HI/LO registers and serves mfhi/mflo.
- Sits between decode and the EX stage; raises stall_o while a multi-cycle op blocks a dependent instruction.

---
 rtl/alu_ctrl_md.sv | 195 +++++++++++++++++++
 tb/tb_alu_ctrl_md.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_md.sv
// ALU control decode with an iterative multiply/divide sequencer.
// Owns the HI/LO registers and serves mfhi/mflo. Sequencer FSM: IDLE -> RUN -> FIX.
module alu_ctrl_md #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [5:0]        funct_i,
    input  logic [2:0]        ALUOp_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [3:0]        ALUCtrl_o,
    output logic              jr_o,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] mf_data_o,
    output logic              mf_valid_o
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  r_hi, r_lo, opnd;
    logic [DATA_W-1:0]  hi, lo;
    logic               is_div, neg_q, neg_r, div0;

    logic               md_op, mf_op, accept;
    logic               in_div, in_signed, in_div0;
    logic [DATA_W-1:0]  abs1, abs2;

    // Step and correction values
    logic [DATA_W:0]    mul_sum, div_shift, div_diff;
    logic [DATA_W-1:0]  mul_hi_nx, mul_lo_nx, div_rem_nx, div_quo_nx;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]  fix_hi, fix_lo;

    assign md_op     = (ALUOp_i == 3'b000) && (funct_i[5:2] == 4'b0110);
    assign mf_op     = (ALUOp_i == 3'b000) && ((funct_i == 6'b010000) || (funct_i == 6'b010010));
    assign accept    = valid_i && md_op && !busy_o;
    assign in_div    = funct_i[1];
    assign in_signed = !funct_i[0];
    assign in_div0   = in_div && (src2_i == '0);
    assign abs1      = (in_signed && src1_i[DATA_W-1]) ? -src1_i : src1_i;
    assign abs2      = (in_signed && src2_i[DATA_W-1]) ? -src2_i : src2_i;

    // ALU operation decode, independent of the sequencer
    always_comb begin
        ALUCtrl_o = 4'b0000;
        jr_o      = 1'b0;
        case (ALUOp_i)
            3'b010: ALUCtrl_o = 4'b0010;
            3'b011: ALUCtrl_o = 4'b0110;
            3'b100: ALUCtrl_o = 4'b0000;
            3'b101: ALUCtrl_o = 4'b0001;
            3'b110: ALUCtrl_o = 4'b1111;
            3'b111: ALUCtrl_o = 4'b0111;
            3'b000: begin
                case (funct_i)
                    6'b100000: ALUCtrl_o = 4'b0010;
                    6'b100010: ALUCtrl_o = 4'b0110;
                    6'b100100: ALUCtrl_o = 4'b0000;
                    6'b100101: ALUCtrl_o = 4'b0001;
                    6'b100110: ALUCtrl_o = 4'b1111;
                    6'b101010: ALUCtrl_o = 4'b0111;
                    6'b001000: begin
                        ALUCtrl_o = 4'b0000;
                        jr_o      = 1'b1;
                    end
                    default:   ALUCtrl_o = 4'b0000;
                endcase
            end
            default: ALUCtrl_o = 4'b0000;
        endcase
    end

    // One shift-add / restoring-divide iteration plus final sign correction
    always_comb begin
        mul_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, opnd} : '0);
        mul_hi_nx  = mul_sum[DATA_W:1];
        mul_lo_nx  = {mul_sum[0], r_lo[DATA_W-1:1]};

        div_shift  = {r_hi, r_lo[DATA_W-1]};
        div_diff   = div_shift - {1'b0, opnd};
        if (!div_diff[DATA_W]) begin
            div_rem_nx = div_diff[DATA_W-1:0];
            div_quo_nx = {r_lo[DATA_W-2:0], 1'b1};
        end else begin
            div_rem_nx = div_shift[DATA_W-1:0];
            div_quo_nx = {r_lo[DATA_W-2:0], 1'b0};
        end

        prod_fix = neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
        if (div0) begin
            fix_hi = r_hi;
            fix_lo = '1;
        end else if (is_div) begin
            fix_hi = neg_r ? -r_hi : r_hi;
            fix_lo = neg_q ? -r_lo : r_lo;
        end else begin
            fix_hi = prod_fix[2*DATA_W-1:DATA_W];
            fix_lo = prod_fix[DATA_W-1:0];
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nx;
    end

    // Sequencer next-state logic; divide by zero skips the iterations
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = in_div0 ? FIX : RUN;
            RUN:     if (cnt == '0) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Sequencer and pipeline-facing outputs
    always_comb begin
        busy_o     = (state != IDLE);
        stall_o    = valid_i && (md_op || mf_op) && busy_o;
        mf_valid_o = valid_i && mf_op && !busy_o;
        mf_data_o  = '0;
        if (mf_valid_o) mf_data_o = funct_i[1] ? lo : hi;
    end

    // Operand capture, iteration datapath and HI/LO write-back
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            opnd   <= '0;
            hi     <= '0;
            lo     <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= (state == FIX);
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= CNT_W'(DATA_W - 1);
                        is_div <= in_div;
                        div0   <= in_div0;
                        neg_q  <= in_signed && (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
                        neg_r  <= in_signed && src1_i[DATA_W-1];
                        // Divide: r_lo holds the dividend and fills with quotient bits.
                        // Multiply: r_lo holds the multiplier and fills with low product bits.
                        if (in_div0) begin
                            r_hi <= src1_i;
                            r_lo <= '0;
                            opnd <= '0;
                        end else if (in_div) begin
                            r_hi <= '0;
                            r_lo <= abs1;
                            opnd <= abs2;
                        end else begin
                            r_hi <= '0;
                            r_lo <= abs2;
                            opnd <= abs1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (is_div) begin
                        r_hi <= div_rem_nx;
                        r_lo <= div_quo_nx;
                    end else begin
                        r_hi <= mul_hi_nx;
                        r_lo <= mul_lo_nx;
                    end
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Scoreboard bench for alu_ctrl_md: stimulus pushes expected mf data and done pulses,
// a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_alu_ctrl_md;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [5:0]    funct_i = '0;
    logic [2:0]    ALUOp_i = '0;
    logic [W-1:0]  src1_i = '0;
    logic [W-1:0]  src2_i = '0;
    logic [3:0]    ALUCtrl_o;
    logic          jr_o, stall_o, busy_o, done_o, mf_valid_o;
    logic [W-1:0]  mf_data_o;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [W-1:0]  mf_q[$];
    int            done_pending = 0;

    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV  = 6'b011010, F_DIVU  = 6'b011011,
                           F_MFHI = 6'b010000, F_MFLO  = 6'b010010;

    alu_ctrl_md #(.DATA_W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .funct_i(funct_i),
        .ALUOp_i(ALUOp_i), .src1_i(src1_i), .src2_i(src2_i),
        .ALUCtrl_o(ALUCtrl_o), .jr_o(jr_o), .stall_o(stall_o), .busy_o(busy_o),
        .done_o(done_o), .mf_data_o(mf_data_o), .mf_valid_o(mf_valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: done pulses and mf reads are matched against the scoreboard
    initial begin
        forever begin
            @(negedge clk_i);
            if (done_o) begin
                n_checks++;
                if (done_pending == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got done_o=1 expected no pulse");
                end else begin
                    done_pending--;
                end
            end
            if (mf_valid_o) begin
                if (mf_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mf_unexpected: got mf_valid_o=1 data %h expected none", mf_data_o);
                end else begin
                    chk("mf_data", mf_data_o, mf_q.pop_front());
                end
            end else if (valid_i) begin
                chk("mf_data_zero", mf_data_o, 0);
            end
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk_i);
        #1;
        valid_i = v; ALUOp_i = op; funct_i = f; src1_i = a; src2_i = b;
    endtask

    // Present an MD op for one cycle; returns #1 after the accept edge
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_done);
        drive(1'b1, 3'b000, f, a, b);
        chk("issue_idle", busy_o, 0);
        if (expect_done) done_pending++;
        drive(1'b0, 3'b000, 6'd0, '0, '0);
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int  nb = 0;
        bit  seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) seen = 1;
            else if (busy_o) nb++;
        end
        chk({name, "_done_seen"}, 64'(seen), 1);
        chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
    endtask

    task automatic read_mf(input logic [5:0] f, input logic [W-1:0] exp);
        mf_q.push_back(exp);
        drive(1'b1, 3'b000, f, '0, '0);
        drive(1'b0, 3'b000, 6'd0, '0, '0);
    endtask

    logic [2:0] d_op  [16] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111,
                              3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                              3'b000, 3'b000, 3'b001, 3'b011};
    logic [5:0] d_fn  [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010,
                              6'b001000, 6'b111111, 6'b001000, 6'b001000};
    logic [3:0] d_exp [16] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1111, 4'b0111,
                              4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1111, 4'b0111,
                              4'b0000, 4'b0000, 4'b0000, 4'b0110};
    logic       d_jr  [16] = '{0,0,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int nst;
        bit seen;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Reset state
        @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        read_mf(F_MFHI, 32'h0);
        read_mf(F_MFLO, 32'h0);

        // Decode sweep
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, d_op[i], d_fn[i], '0, '0);
            #1;
            chk($sformatf("dec_ctrl_%0d", i), ALUCtrl_o, d_exp[i]);
            chk($sformatf("dec_jr_%0d", i), jr_o, d_jr[i]);
        end

        // mult 7 x -3 with mfhi presented five cycles after issue
        issue(F_MULT, 32'd7, 32'hFFFFFFFD, 1);
        repeat (4) @(posedge clk_i);
        #1;
        valid_i = 1'b1; ALUOp_i = 3'b000; funct_i = F_MFHI;
        mf_q.push_back(32'hFFFFFFFF);
        nst = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                chk("mfhi_stall_in_done", stall_o, 0);
            end else begin
                if (stall_o !== 1'b1 || mf_valid_o !== 1'b0) begin
                    chk("mfhi_stall_hold", {stall_o, mf_valid_o}, 2'b10);
                end
                nst++;
            end
        end
        chk("mfhi_done_seen", 64'(seen), 1);
        chk("mfhi_stall_cycles", 64'(nst), 64'(W + 1 - 4));
        drive(1'b0, 3'b000, 6'd0, '0, '0);
        read_mf(F_MFLO, 32'hFFFFFFEB);

        // multu
        issue(F_MULTU, 32'hFFFFFFFF, 32'd2, 1);
        wait_done("multu", W + 1);
        read_mf(F_MFHI, 32'h00000001);
        read_mf(F_MFLO, 32'hFFFFFFFE);

        // Signed divides, including the overflow case
        issue(F_DIV, 32'hFFFFFFF9, 32'd2, 1);
        wait_done("div", W + 1);
        read_mf(F_MFLO, 32'hFFFFFFFD);
        read_mf(F_MFHI, 32'hFFFFFFFF);
        issue(F_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
        wait_done("div_ovf", W + 1);
        read_mf(F_MFLO, 32'h80000000);
        read_mf(F_MFHI, 32'h00000000);

        // Divide by zero
        issue(F_DIVU, 32'h00001234, 32'd0, 1);
        wait_done("divz", 1);
        read_mf(F_MFLO, 32'hFFFFFFFF);
        read_mf(F_MFHI, 32'h00001234);

        // Back-to-back: second op held until the done cycle, accepted there
        issue(F_MULTU, 32'hFFFFFFFF, 32'd2, 1);
        valid_i = 1'b1; ALUOp_i = 3'b000; funct_i = F_MULT; src1_i = 32'd5; src2_i = 32'hFFFFFFFA;
        done_pending++;
        seen = 0;
        nst = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1;
                chk("b2b_stall_in_done", stall_o, 0);
            end else if (stall_o) begin
                nst++;
            end
        end
        chk("b2b_done_seen", 64'(seen), 1);
        chk("b2b_stall_cycles", 64'(nst), 64'(W + 1));
        drive(1'b0, 3'b000, 6'd0, '0, '0);
        wait_done("b2b_second", W + 1);
        read_mf(F_MFHI, 32'hFFFFFFFF);
        read_mf(F_MFLO, 32'hFFFFFFE2);

        // Asynchronous reset mid-RUN: abandons the op, clears HI/LO
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        repeat (10) @(posedge clk_i);
        #1;
        valid_i = 1'b1; ALUOp_i = 3'b000; funct_i = F_MFHI;
        #1 rst_i = 1'b0;
        #1;
        chk("arst_busy", busy_o, 0);
        chk("arst_hi", mf_data_o, 0);
        funct_i = F_MFLO;
        #0.5;
        chk("arst_lo", mf_data_o, 0);
        valid_i = 1'b0;
        #0.5 rst_i = 1'b1;
        repeat (W + 5) @(posedge clk_i);
        read_mf(F_MFHI, 32'h0);
        read_mf(F_MFLO, 32'h0);

        repeat (2) @(posedge clk_i);
        chk("sb_mf_empty", 64'(mf_q.size()), 0);
        chk("sb_done_empty", 64'(done_pending), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
